ad7656_adc_emulator: RTL and testbench

Synthesizable responder for the AD7656 parallel read interface. It answers CONVST with BUSY and serves six 16-bit channel words on DB over successive CS/RD strobes. It replaces the physical ADC in FPGA loopback tests so the ADC read driver can be validated on hardware without an analog front end. Its channel values come either from fabric inputs or from an internal ramp generator.

---
 rtl/ad7656_adc_emulator.sv | 138 +++++++++++++
 tb/tb_ad7656_adc_emulator.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ad7656_adc_emulator.sv
// AD7656 parallel-read responder: answers CONVST with BUSY and serves six
// channel words on DB over CS/RD strobes, from fabric inputs or a test ramp.
`timescale 1ns/1ps
module ad7656_adc_emulator #(
  parameter int unsigned CONV_CYCLES = 300,
  parameter logic [15:0] RAMP_STEP   = 16'h0001
) (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic        convst_a_i,
  input  logic        convst_b_i,
  input  logic        convst_c_i,
  input  logic        cs_n_i,
  input  logic        rd_n_i,
  input  logic        test_mode_i,
  input  logic [15:0] ch1_data_i,
  input  logic [15:0] ch2_data_i,
  input  logic [15:0] ch3_data_i,
  input  logic [15:0] ch4_data_i,
  input  logic [15:0] ch5_data_i,
  input  logic [15:0] ch6_data_i,
  output logic        busy_o,
  output logic [15:0] db_o,
  output logic        db_oe_o,
  output logic [15:0] conv_cnt_o,
  output logic        overrun_o
);

  localparam int unsigned DW  = 16;
  localparam int unsigned NCH = 6;
  localparam int unsigned PW  = 3;
  localparam int unsigned CW  = 16;

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state;
  logic [CW-1:0]   busy_cnt;
  logic [PW-1:0]   ptr;
  logic [DW-1:0]   ramp;
  logic [DW-1:0]   sample [NCH];
  logic [DW-1:0]   result [NCH];
  logic [DW-1:0]   ch_data [NCH];
  logic [DW-1:0]   samp_src_c [NCH];

  // [0]=sync stage 1, [1]=sync stage 2, [2]=history
  logic [2:0] cv_sh, cs_sh, rd_sh;

  logic trigger_c, rd_fall_c, rd_rise_c, cs_act_c;

  assign ch_data[0] = ch1_data_i;
  assign ch_data[1] = ch2_data_i;
  assign ch_data[2] = ch3_data_i;
  assign ch_data[3] = ch4_data_i;
  assign ch_data[4] = ch5_data_i;
  assign ch_data[5] = ch6_data_i;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cv_sh <= 3'b000;
      cs_sh <= 3'b111;
      rd_sh <= 3'b111;
    end else begin
      cv_sh <= {cv_sh[1:0], convst_a_i | convst_b_i | convst_c_i};
      cs_sh <= {cs_sh[1:0], cs_n_i};
      rd_sh <= {rd_sh[1:0], rd_n_i};
    end
  end

  assign trigger_c = cv_sh[1] & ~cv_sh[2];
  assign rd_fall_c = ~rd_sh[1] & rd_sh[2];
  assign rd_rise_c = rd_sh[1] & ~rd_sh[2];
  assign cs_act_c  = ~cs_sh[1];

  // Channel N in ramp mode is offset by (N-1)*0x1000 from the ramp
  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      samp_src_c[i] = test_mode_i ? (ramp + DW'(i * 4096)) : ch_data[i];
    end
  end

  // Conversion FSM with busy counter, sample/result banks and counters
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      busy_cnt   <= '0;
      busy_o     <= 1'b0;
      conv_cnt_o <= '0;
      overrun_o  <= 1'b0;
      ramp       <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        sample[i] <= '0;
        result[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (trigger_c) begin
            state    <= CONV;
            busy_cnt <= CW'(CONV_CYCLES - 1);
            busy_o   <= 1'b1;
            for (int i = 0; i < int'(NCH); i++) sample[i] <= samp_src_c[i];
          end
        end
        CONV: begin
          if (trigger_c) overrun_o <= 1'b1;
          if (busy_cnt == '0) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            conv_cnt_o <= conv_cnt_o + 16'd1;
            ramp       <= ramp + RAMP_STEP;
            for (int i = 0; i < int'(NCH); i++) result[i] <= sample[i];
          end else begin
            busy_cnt <= busy_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read port: word load on RD fall, pointer advance on RD rise
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr     <= '0;
      db_o    <= '0;
      db_oe_o <= 1'b0;
    end else begin
      db_oe_o <= ~cs_sh[1] & ~rd_sh[1];
      if (rd_fall_c && cs_act_c) db_o <= result[ptr];
      if (state == IDLE && trigger_c) begin
        ptr <= '0;
      end else if (rd_rise_c && cs_act_c) begin
        ptr <= (ptr == PW'(NCH - 1)) ? '0 : ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ad7656_adc_emulator.sv
// Scoreboard bench for ad7656_adc_emulator: reads push expected words,
// a monitor pops and compares on each rising db_oe_o.
`timescale 1ns/1ps
module tb_ad7656_adc_emulator;

  logic        sys_clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        convst_a_i = 1'b0, convst_b_i = 1'b0, convst_c_i = 1'b0;
  logic        cs_n_i = 1'b1, rd_n_i = 1'b1;
  logic        test_mode_i = 1'b0;
  logic [15:0] ch_in [6];
  logic        busy_o, db_oe_o, overrun_o;
  logic [15:0] db_o, conv_cnt_o;

  int checks = 0;
  int failures = 0;
  logic [15:0] sb_q [$];
  logic prev_oe = 1'b0;

  always #5 sys_clk_i = ~sys_clk_i;

  ad7656_adc_emulator #(.CONV_CYCLES(300), .RAMP_STEP(16'h0001)) dut (
    .sys_clk_i(sys_clk_i), .rst_n_i(rst_n_i),
    .convst_a_i(convst_a_i), .convst_b_i(convst_b_i), .convst_c_i(convst_c_i),
    .cs_n_i(cs_n_i), .rd_n_i(rd_n_i), .test_mode_i(test_mode_i),
    .ch1_data_i(ch_in[0]), .ch2_data_i(ch_in[1]), .ch3_data_i(ch_in[2]),
    .ch4_data_i(ch_in[3]), .ch5_data_i(ch_in[4]), .ch6_data_i(ch_in[5]),
    .busy_o(busy_o), .db_o(db_o), .db_oe_o(db_oe_o),
    .conv_cnt_o(conv_cnt_o), .overrun_o(overrun_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every new DB drive window must match the oldest queued read
  always @(negedge sys_clk_i) begin
    if (rst_n_i && db_oe_o && !prev_oe) begin
      if (sb_q.size() == 0) check("unexpected_db_oe", 32'(db_o), 32'hDEAD_0000);
      else check("db_word", 32'(db_o), 32'(sb_q.pop_front()));
    end
    prev_oe <= rst_n_i ? db_oe_o : 1'b0;
  end

  task automatic do_read(input logic [15:0] exp);
    @(negedge sys_clk_i) cs_n_i = 1'b0;
    sb_q.push_back(exp);
    @(negedge sys_clk_i) rd_n_i = 1'b0;
    repeat (9) @(negedge sys_clk_i);
    rd_n_i = 1'b1;
    repeat (3) @(negedge sys_clk_i);
    cs_n_i = 1'b1;
    @(negedge sys_clk_i);
  endtask

  task automatic pulse_convst();
    @(negedge sys_clk_i) convst_a_i = 1'b1;
    repeat (3) @(negedge sys_clk_i);
    convst_a_i = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl);
    int n = 0;
    while (busy_o !== lvl && n < 1000) begin
      @(negedge sys_clk_i);
      n++;
    end
    if (busy_o !== lvl) check("busy_wait_timeout", 32'(busy_o), 32'(lvl));
  endtask

  // One conversion; optional second CONVST (on convst_b) at busy cycle over_at
  task automatic run_conv(input int over_at, output int width);
    pulse_convst();
    wait_busy(1'b1);
    width = 0;
    while (busy_o === 1'b1 && width < 1000) begin
      width++;
      if (width == over_at) convst_b_i = 1'b1;
      if (width == over_at + 4) convst_b_i = 1'b0;
      @(negedge sys_clk_i);
    end
    convst_b_i = 1'b0;
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w;
    logic saw_oe;
    for (int i = 0; i < 6; i++) ch_in[i] = 16'h0;
    repeat (3) @(negedge sys_clk_i);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_db_oe", 32'(db_oe_o), 0);
    check("rst_db", 32'(db_o), 0);
    check("rst_conv_cnt", 32'(conv_cnt_o), 0);
    check("rst_overrun", 32'(overrun_o), 0);
    rst_n_i = 1'b1;
    repeat (3) @(negedge sys_clk_i);

    // Basic read of six channels, then pointer wrap
    for (int i = 0; i < 6; i++) ch_in[i] = 16'(16'h1111 * (i + 1));
    run_conv(0, w);
    check("basic_busy_width", 32'(w), 300);
    check("basic_conv_cnt", 32'(conv_cnt_o), 1);
    for (int i = 0; i < 6; i++) do_read(16'(16'h1111 * (i + 1)));
    do_read(16'h1111);

    // RD toggling with CS high must neither drive DB nor move the pointer
    saw_oe = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge sys_clk_i) rd_n_i = 1'b0;
      repeat (3) begin @(negedge sys_clk_i); saw_oe |= db_oe_o; end
      rd_n_i = 1'b1;
      repeat (3) begin @(negedge sys_clk_i); saw_oe |= db_oe_o; end
    end
    check("gated_db_oe", 32'(saw_oe), 0);
    do_read(16'h2222);

    // Reads during conversion return the previous results
    for (int i = 0; i < 6; i++) ch_in[i] = 16'h00AA;
    run_conv(0, w);
    for (int i = 0; i < 6; i++) ch_in[i] = 16'h0055;
    pulse_convst();
    wait_busy(1'b1);
    do_read(16'h00AA);
    check("busy_during_read", 32'(busy_o), 1);
    wait_busy(1'b0);
    do_read(16'h0055);
    check("conv_cnt_after_ab", 32'(conv_cnt_o), 3);
    check("no_overrun_yet", 32'(overrun_o), 0);

    // Overrun: second CONVST 100 cycles in
    run_conv(100, w);
    check("overrun_busy_width", 32'(w), 300);
    check("overrun_flag", 32'(overrun_o), 1);
    check("overrun_conv_cnt", 32'(conv_cnt_o), 4);

    // Asynchronous reset mid-conversion
    pulse_convst();
    wait_busy(1'b1);
    repeat (150) @(negedge sys_clk_i);
    rst_n_i = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_o), 0);
    check("midrst_db_oe", 32'(db_oe_o), 0);
    check("midrst_conv_cnt", 32'(conv_cnt_o), 0);
    check("midrst_overrun", 32'(overrun_o), 0);
    @(negedge sys_clk_i) rst_n_i = 1'b1;
    repeat (3) @(negedge sys_clk_i);

    // Ramp mode after reset: third conversion samples ramp = 2
    test_mode_i = 1'b1;
    run_conv(0, w);
    check("ramp_busy_width", 32'(w), 300);
    run_conv(0, w);
    run_conv(0, w);
    check("ramp_conv_cnt", 32'(conv_cnt_o), 3);
    check("ramp_no_overrun", 32'(overrun_o), 0);
    for (int i = 0; i < 6; i++) do_read(16'(16'h0002 + 16'h1000 * i));

    repeat (5) @(negedge sys_clk_i);
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
